popcount_frame_acc: RTL and testbench

//  - Downstream consumer of the 32-bit popcount stage. Accepts 32-bit words as a stream with a valid/ready

---
 rtl/popcount_pkg.sv | 17 +
 rtl/popcount_tree.sv | 32 +++
 rtl/popcount_frame_acc.sv | 127 ++++++++++++
 tb/tb_popcount_frame_acc.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared defaults, width helper and frame result type for the popcount frame accumulator.
package popcount_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int ACC_W_DEF  = 16;

  function automatic int pc_width(input int w);
    return $clog2(w + 1);
  endfunction

  typedef struct packed {
    logic [ACC_W_DEF-1:0] total;
    logic [ACC_W_DEF-1:0] words;
    logic                 overflow;
  } frame_result_t;

endpackage

// File: rtl/popcount_tree.sv
// Balanced binary adder tree counting the set bits of a WORD_W-bit word.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PC_W   = pc_width(WORD_W)
) (
  input  logic [WORD_W-1:0] data,
  output logic [PC_W-1:0]   count
);

  localparam int LEAVES = 1 << $clog2(WORD_W);

  // Heap-ordered nodes: node[1] is the root, leaves sit at LEAVES..2*LEAVES-1.
  logic [PC_W-1:0] node [1:2*LEAVES-1];

  genvar i;
  for (i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < WORD_W) begin : g_bit
      assign node[LEAVES+i] = {{(PC_W-1){1'b0}}, data[i]};
    end else begin : g_pad
      assign node[LEAVES+i] = '0;
    end
  end

  for (i = 1; i < LEAVES; i++) begin : g_add
    assign node[i] = node[2*i] + node[2*i+1];
  end

  assign count = node[1];

endmodule

// File: rtl/popcount_frame_acc.sv
// Per-frame popcount accumulator with valid/ready on both sides.
// Optional threshold flag m_above is enabled by defining POPCOUNT_THRESHOLD_EN.
module popcount_frame_acc
  import popcount_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACC_W-1:0]  m_total,
  output logic [ACC_W-1:0]  m_words,
  output logic              m_overflow
`ifdef POPCOUNT_THRESHOLD_EN
  ,
  input  logic [ACC_W-1:0]  cfg_thresh,
  output logic              m_above
`endif
);

  localparam int PC_W = pc_width(WORD_W);

  logic [WORD_W-1:0] s1_data;
  logic              s1_last;
  logic              s1_valid;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  wcnt;
  logic              ovf;
  logic [PC_W-1:0]   pc;
  logic              blocked;
  logic              retire;
  logic [ACC_W:0]    acc_sum;
  logic [ACC_W:0]    wcnt_sum;
  logic [ACC_W-1:0]  acc_next;
  logic [ACC_W-1:0]  wcnt_next;
  logic              sat_hit;

  popcount_tree #(.WORD_W(WORD_W), .PC_W(PC_W)) u_tree (
    .data  (s1_data),
    .count (pc)
  );

  // Stall decision and saturating next-sum computation for the word in S1.
  always_comb begin
    blocked  = s1_valid && s1_last && m_valid && !m_ready;
    retire   = s1_valid && !blocked;
    acc_sum  = {1'b0, acc} + (ACC_W+1)'(pc);
    wcnt_sum = {1'b0, wcnt} + {{ACC_W{1'b0}}, 1'b1};
    if (acc_sum[ACC_W]) begin
      acc_next = '1;
    end else begin
      acc_next = acc_sum[ACC_W-1:0];
    end
    if (wcnt_sum[ACC_W]) begin
      wcnt_next = '1;
    end else begin
      wcnt_next = wcnt_sum[ACC_W-1:0];
    end
    sat_hit = acc_sum[ACC_W] | wcnt_sum[ACC_W];
  end

  assign s_ready = !blocked;

  // Input register stage; a new word may load on the same edge the old one retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
    end else if (s_valid && s_ready) begin
      s1_valid <= 1'b1;
      s1_data  <= s_data;
      s1_last  <= s_last;
    end else if (retire) begin
      s1_valid <= 1'b0;
    end
  end

  // Running frame accumulators, cleared when the last word retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      wcnt <= '0;
      ovf  <= 1'b0;
    end else if (retire) begin
      if (s1_last) begin
        acc  <= '0;
        wcnt <= '0;
        ovf  <= 1'b0;
      end else begin
        acc  <= acc_next;
        wcnt <= wcnt_next;
        ovf  <= ovf | sat_hit;
      end
    end
  end

  // Result register; a retiring last overrides a same-cycle handshake so frames go back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    <= 1'b0;
      m_total    <= '0;
      m_words    <= '0;
      m_overflow <= 1'b0;
`ifdef POPCOUNT_THRESHOLD_EN
      m_above    <= 1'b0;
`endif
    end else if (retire && s1_last) begin
      m_valid    <= 1'b1;
      m_total    <= acc_next;
      m_words    <= wcnt_next;
      m_overflow <= ovf | sat_hit;
`ifdef POPCOUNT_THRESHOLD_EN
      m_above    <= (acc_next > cfg_thresh);
`endif
    end else if (m_ready) begin
      m_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_popcount_frame_acc.sv
// Scoreboard bench for popcount_frame_acc (ACC_W=8); checks m_above too when POPCOUNT_THRESHOLD_EN is defined.
module tb_popcount_frame_acc;

  localparam int WORD_W = 32;
  localparam int ACC_W  = 8;
  localparam int MAXV   = (1 << ACC_W) - 1;
  localparam int THRESH = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [WORD_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [ACC_W-1:0]  m_total;
  logic [ACC_W-1:0]  m_words;
  logic              m_overflow;
`ifdef POPCOUNT_THRESHOLD_EN
  logic [ACC_W-1:0]  cfg_thresh;
  logic              m_above;
`endif

  typedef struct {
    int total;
    int words;
    bit ovf;
    bit above;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   total_cnt = 0;
  int   bad_cnt   = 0;
  int   fr_ones   = 0;
  int   fr_words  = 0;
  int   mr_mode   = 0;  // 0: ready high, 1: random, 2: ready low

  always #5 clk = ~clk;

  popcount_frame_acc #(.WORD_W(WORD_W), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_total    (m_total),
    .m_words    (m_words),
    .m_overflow (m_overflow)
`ifdef POPCOUNT_THRESHOLD_EN
    ,
    .cfg_thresh (cfg_thresh),
    .m_above    (m_above)
`endif
  );

  task automatic check(input string name, input int act, input int req);
    total_cnt++;
    if (act != req) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a frame's result is the clamped sum of set bits and the clamped word count.
  task automatic model_accept(input logic [WORD_W-1:0] d, input logic l);
    exp_t x;
    fr_ones  += $countones(d);
    fr_words += 1;
    if (l) begin
      x.total = (fr_ones > MAXV) ? MAXV : fr_ones;
      x.words = (fr_words > MAXV) ? MAXV : fr_words;
      x.ovf   = (fr_ones > MAXV) || (fr_words > MAXV);
      x.above = (x.total > THRESH);
      sb.push_back(x);
      fr_ones  = 0;
      fr_words = 0;
    end
  endtask

  task automatic send_word(input logic [WORD_W-1:0] d, input logic l);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      $display("FAIL accept_timeout: s_ready stayed 0, required 1");
      $fatal(1, "input stalled");
    end
    model_accept(d, l);
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    s_valid = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", int'(ok), 1);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    case (mr_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Monitor: every result handshake pops the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        got = sb.pop_front();
        check("m_total", int'(m_total), got.total);
        check("m_words", int'(m_words), got.words);
        check("m_overflow", int'(m_overflow), int'(got.ovf));
`ifdef POPCOUNT_THRESHOLD_EN
        check("m_above", int'(m_above), int'(got.above));
`endif
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b1;
`ifdef POPCOUNT_THRESHOLD_EN
    cfg_thresh = ACC_W'(THRESH);
`endif
    repeat (2) @(negedge clk);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_m_total", int'(m_total), 0);
    check("rst_m_words", int'(m_words), 0);
    check("rst_m_overflow", int'(m_overflow), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Three-word frame with latency check on the last word.
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(32'h0000_0001, 1'b0);
    send_word(32'h8000_0000, 1'b1);
    s_valid = 1'b0;
    @(negedge clk);
    check("lat_before", int'(m_valid), 0);
    @(negedge clk);
    check("lat_after", int'(m_valid), 1);
    wait_drain();

    // Backpressure: second frame's last stalls in S1 until the first result is taken.
    mr_mode = 2;
    idle(1);
    send_word(32'h0000_0001, 1'b1);
    idle(1);
    send_word(32'h0000_0007, 1'b1);
    s_valid = 1'b0;
    @(negedge clk);
    check("bp_s_ready", int'(s_ready), 0);
    check("bp_m_valid", int'(m_valid), 1);
    mr_mode = 0;
    @(negedge clk);
    check("bp_release_s_ready", int'(s_ready), 1);
    @(negedge clk);
    check("bp_b2b_m_valid", int'(m_valid), 1);
    wait_drain();

    // Saturation, then a clean frame.
    for (int i = 0; i < 9; i++) send_word(32'hFFFF_FFFF, 1'(i == 8));
    send_word(32'h0000_0003, 1'b1);
    wait_drain();

    // Threshold boundary frames (totals 32 and 33).
    send_word(32'hFFFF_FFFF, 1'b1);
    send_word(32'hFFFF_FFFF, 1'b0);
    send_word(32'h0000_0001, 1'b1);
    wait_drain();

    // Reset in the middle of a frame.
    send_word(32'h0000_AAAA, 1'b0);
    send_word(32'h0000_0005, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    fr_ones  = 0;
    fr_words = 0;
    #1;
    check("midrst_m_valid", int'(m_valid), 0);
    check("midrst_s_ready", int'(s_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    send_word(32'h0000_000F, 1'b1);
    wait_drain();

    // Random frames with random gaps and random output backpressure.
    mr_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        logic [WORD_W-1:0] d;
        d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : WORD_W'($urandom);
        send_word(d, 1'(i == len - 1));
        if ($urandom_range(0, 9) < 3) idle($urandom_range(1, 3));
      end
    end
    mr_mode = 0;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
